// File: rtl/captura_vga.sv
// captura_vga -- frame-capture receiver for a VGA-timed pixel stream.
//
// Registers the sync/blank/colour inputs once, converts every active pixel to
// 8-bit luminance, packs four pixels per 32-bit word (first pixel in bits 7:0)
// and writes an ANCHO x ALTO window of one frame to RAM, row-major from word 0.
// A capture is armed by a one-cycle start pulse and begins at the next vsync
// falling edge.
//
// Ports:
//   clock_25      pixel clock, rising edge
//   reset         asynchronous, active-low
//   start         one-cycle pulse arming a capture (ignored unless idle)
//   red/green/blue pixel colour, valid while n_blank = 1
//   hsync, vsync  active-low line / frame sync
//   n_blank       1 = active pixel this cycle
//   address       RAM word address, valid with write_enable
//   data_dram     packed luminance word, valid with write_enable
//   write_enable  one-cycle write strobe
//   busy          capture armed or in progress
//   frame_done    one-cycle pulse at the end of a capture
//   incompleto    sticky: last capture was cut short by an early vsync
module captura_vga #(
  parameter int ANCHO = 256,
  parameter int ALTO  = 256
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        n_blank,
  output logic [31:0] address,
  output logic [31:0] data_dram,
  output logic        write_enable,
  output logic        busy,
  output logic        frame_done,
  output logic        incompleto
);

  localparam int CW = $clog2(ANCHO + 1);
  localparam int FW = $clog2(ALTO + 1);
  localparam logic [CW-1:0] ANCHO_C = CW'(ANCHO);
  localparam logic [FW-1:0] ALTO_C  = FW'(ALTO);

  typedef enum logic [1:0] {IDLE, ESPERA_VSYNC, CAPTURA, FIN} estado_t;
  estado_t estado, estado_next;

  // Input stage and edge-detect history
  logic [7:0] r_q, g_q, b_q;
  logic       hs_q, vs_q, nb_q, vs_prev, nb_prev;
  logic       vs_fall, nb_fall, pix_valid;
  logic [7:0] gris;

  // Capture datapath
  logic [CW-1:0] col;
  logic [FW-1:0] fila;
  logic [31:0]   word_buf;
  logic [31:0]   word_cnt;
  logic          word_full;   // lane 3 just packed; word goes out next edge

  // FSM -> datapath strobes
  logic arm, enter_cap, abort;

  assign vs_fall   = vs_prev & ~vs_q;
  assign nb_fall   = nb_prev & ~nb_q;
  // A pixel flagged active during hsync is not a real pixel; never count it.
  assign pix_valid = nb_q & hs_q;
  // (r + 2g + b) fits in 10 bits; dropping the two LSBs gives 0..255.
  assign gris      = 8'(({2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, b_q}) >> 2);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) estado <= IDLE;
    // NOTE: state is updated with non-blocking assignments so every process
    // sampling it on this edge sees the pre-edge value.
    else        estado <= estado_next;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    estado_next = estado;
    busy        = 1'b0;
    frame_done  = 1'b0;
    arm         = 1'b0;
    enter_cap   = 1'b0;
    abort       = 1'b0;
    case (estado)
      IDLE: begin
        if (start) begin
          arm         = 1'b1;
          estado_next = ESPERA_VSYNC;
        end
      end
      ESPERA_VSYNC: begin
        busy = 1'b1;
        if (vs_fall) begin
          enter_cap   = 1'b1;
          estado_next = CAPTURA;
        end
      end
      CAPTURA: begin
        busy = 1'b1;
        // Leave only once the last word has actually been issued.
        if (fila == ALTO_C && !word_full) begin
          estado_next = FIN;
        end else if (vs_fall && fila != ALTO_C) begin
          abort       = 1'b1;
          estado_next = FIN;
        end
      end
      FIN: begin
        frame_done  = 1'b1;
        estado_next = IDLE;
      end
      default: estado_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      nb_q         <= 1'b0;
      vs_prev      <= 1'b0;
      nb_prev      <= 1'b0;
      col          <= '0;
      fila         <= '0;
      word_buf     <= '0;
      word_cnt     <= '0;
      word_full    <= 1'b0;
      address      <= '0;
      data_dram    <= '0;
      write_enable <= 1'b0;
      incompleto   <= 1'b0;
    end else begin
      r_q     <= red;
      g_q     <= green;
      b_q     <= blue;
      hs_q    <= hsync;
      vs_q    <= vsync;
      nb_q    <= n_blank;
      vs_prev <= vs_q;
      nb_prev <= nb_q;

      // A packed word is issued even if the capture is ending on this edge.
      write_enable <= word_full;
      word_full    <= 1'b0;
      if (word_full) begin
        data_dram <= word_buf;
        address   <= word_cnt;
        word_cnt  <= word_cnt + 32'd1;
      end

      if (arm) begin
        incompleto <= 1'b0;
        word_cnt   <= '0;
        col        <= '0;
        fila       <= '0;
      end

      if (enter_cap) begin
        col  <= '0;
        fila <= '0;
      end

      if (abort) incompleto <= 1'b1;

      // An aborted capture packs nothing more; the partial word is dropped.
      if (estado == CAPTURA && !abort) begin
        if (pix_valid) begin
          if (col < ANCHO_C) begin
            if (fila < ALTO_C) begin
              word_buf[{col[1:0], 3'b000} +: 8] <= gris;
              if (col[1:0] == 2'd3) word_full <= 1'b1;
            end
            col <= col + CW'(1);
          end
        end else if (nb_fall) begin
          col <= '0;
          if (fila < ALTO_C) fila <= fila + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_captura_vga.sv
// Directed testbench for captura_vga with an 8 x 2 capture window.
module tb_captura_vga;

  localparam int ANCHO = 8;
  localparam int ALTO  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, n_blank;
  logic [31:0] address, data_dram;
  logic        write_enable, busy, frame_done, incompleto;

  captura_vga #(.ANCHO(ANCHO), .ALTO(ALTO)) dut (
    .clock_25     (clk),
    .reset        (rst_n),
    .start        (start),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync        (hsync),
    .vsync        (vsync),
    .n_blank      (n_blank),
    .address      (address),
    .data_dram    (data_dram),
    .write_enable (write_enable),
    .busy         (busy),
    .frame_done   (frame_done),
    .incompleto   (incompleto)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Write / done monitor, sampled on the falling edge.
  logic [31:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  int n_wr   = 0;
  int n_done = 0;

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      if (n_wr < 256) begin
        wr_addr[n_wr] = address;
        wr_data[n_wr] = data_dram;
      end
      n_wr++;
    end
    if (frame_done === 1'b1) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One pixel-clock cycle of input, changed on the falling edge.
  task automatic drive(input bit vs, input bit hs, input bit nb,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    vsync = vs; hsync = hs; n_blank = nb;
    red = r; green = g; blue = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 1, 0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: all channels = row*8+col; mode 1: row*16+col; mode 2: arithmetic table
  task automatic pixel(input int mode, input int row, input int col,
                       output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    r = 8'd0; g = 8'd0; b = 8'd0;
    if (mode == 0) begin
      r = 8'(row * 8 + col); g = r; b = r;
    end else if (mode == 1) begin
      r = 8'(row * 16 + col); g = r; b = r;
    end else begin
      case (col)
        0: begin r = 8'd255; g = 8'd255; b = 8'd255; end // 0xFF
        1: begin r = 8'd4;   g = 8'd0;   b = 8'd0;   end // 0x01
        2: begin r = 8'd0;   g = 8'd2;   b = 8'd0;   end // 0x01
        3: begin r = 8'd0;   g = 8'd0;   b = 8'd8;   end // 0x02 -> wait: 8>>2 = 2
        4: begin r = 8'd10;  g = 8'd20;  b = 8'd30;  end // 80>>2 = 0x14
        5: begin r = 8'd1;   g = 8'd1;   b = 8'd1;   end // 4>>2  = 0x01
        6: begin r = 8'd3;   g = 8'd0;   b = 8'd0;   end // 3>>2  = 0x00
        default: begin r = 8'd100; g = 8'd50; b = 8'd200; end // 400>>2 = 0x64
      endcase
    end
  endtask

  task automatic vsync_pulse;
    repeat (2) drive(0, 1, 0, 8'd0, 8'd0, 8'd0);
    repeat (2) drive(1, 1, 0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic line(input int row, input int width, input int mode);
    logic [7:0] r, g, b;
    repeat (2) drive(1, 0, 0, 8'd0, 8'd0, 8'd0);
    repeat (2) drive(1, 1, 0, 8'd0, 8'd0, 8'd0);
    for (int c = 0; c < width; c++) begin
      pixel(mode, row, c, r, g, b);
      drive(1, 1, 1, r, g, b);
    end
    repeat (2) drive(1, 1, 0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic frame(input int lines, input int width, input int mode, input bit end_vs);
    vsync_pulse();
    for (int row = 0; row < lines; row++) line(row, width, mode);
    if (end_vs) vsync_pulse();
    idle(6);
  endtask

  // Expected word from a linear pattern: byte(row, col) = row*stride + col.
  function automatic logic [31:0] pat_word(input int w, input int stride);
    logic [31:0] v;
    int row, c0;
    row = w / (ANCHO / 4);
    c0  = (w % (ANCHO / 4)) * 4;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(row * stride + c0 + i);
    return v;
  endfunction

  int base_wr, base_done;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    vsync = 1'b1; hsync = 1'b1; n_blank = 1'b0;
    red = '0; green = '0; blue = '0;

    // Reset with random inputs
    repeat (5) drive(1'($urandom), 1'($urandom), 1'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rst_address", address, 32'd0);
    check("rst_data", data_dram, 32'd0);
    check("rst_we", write_enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_incompleto", incompleto, 1'b0);
    idle(2);
    rst_n = 1'b1;
    frame(2, 8, 0, 0);
    frame(2, 8, 0, 0);
    check("no_start_writes", 32'(n_wr), 32'd0);
    check("no_start_busy", busy, 1'b0);

    // Full frame, pixel index pattern
    base_wr = n_wr; base_done = n_done;
    pulse_start();
    check("full_busy_rise", busy, 1'b1);
    frame(2, 8, 0, 0);
    check("full_nwr", 32'(n_wr - base_wr), 32'd4);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("full_addr%0d", w), wr_addr[base_wr + w], 32'(w));
      check($sformatf("full_data%0d", w), wr_data[base_wr + w], pat_word(w, 8));
    end
    check("full_word0", wr_data[base_wr], 32'h0302_0100);
    check("full_word3", wr_data[base_wr + 3], 32'h0F0E_0D0C);
    check("full_done", 32'(n_done - base_done), 32'd1);
    check("full_incompleto", incompleto, 1'b0);
    check("full_busy_fall", busy, 1'b0);

    // Luminance arithmetic
    base_wr = n_wr;
    pulse_start();
    frame(2, 8, 2, 0);
    check("arith_nwr", 32'(n_wr - base_wr), 32'd4);
    check("arith_w0", wr_data[base_wr],     32'h0201_01FF);
    check("arith_w1", wr_data[base_wr + 1], 32'h6400_0114);
    check("arith_w2", wr_data[base_wr + 2], 32'h0201_01FF);
    check("arith_w3", wr_data[base_wr + 3], 32'h6400_0114);

    // Window clipping: 12-pixel lines, 4 lines
    base_wr = n_wr; base_done = n_done;
    pulse_start();
    frame(4, 12, 1, 0);
    check("clip_nwr", 32'(n_wr - base_wr), 32'd4);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("clip_addr%0d", w), wr_addr[base_wr + w], 32'(w));
      check($sformatf("clip_data%0d", w), wr_data[base_wr + w], pat_word(w, 16));
    end
    check("clip_done", 32'(n_done - base_done), 32'd1);

    // Early frame end after one line
    base_wr = n_wr; base_done = n_done;
    pulse_start();
    frame(1, 8, 0, 1);
    check("early_nwr", 32'(n_wr - base_wr), 32'd2);
    check("early_w0", wr_data[base_wr],     32'h0302_0100);
    check("early_w1", wr_data[base_wr + 1], 32'h0706_0504);
    check("early_done", 32'(n_done - base_done), 32'd1);
    check("early_incompleto", incompleto, 1'b1);
    check("early_busy", busy, 1'b0);
    pulse_start();
    check("restart_clears_inc", incompleto, 1'b0);
    check("restart_busy", busy, 1'b1);

    // start while busy is ignored; the armed capture runs once
    base_wr = n_wr; base_done = n_done;
    pulse_start();
    check("busy_start_busy", busy, 1'b1);
    frame(2, 8, 0, 0);
    check("busy_start_nwr", 32'(n_wr - base_wr), 32'd4);
    check("busy_start_done", 32'(n_done - base_done), 32'd1);
    check("busy_start_w3", wr_data[base_wr + 3], 32'h0F0E_0D0C);
    idle(4);
    check("busy_start_idle", busy, 1'b0);

    // Reset mid-capture after the second write
    base_wr = n_wr; base_done = n_done;
    pulse_start();
    vsync_pulse();
    line(0, 8, 0);
    repeat (2) @(negedge clk);
    check("rst_mid_nwr", 32'(n_wr - base_wr), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we", write_enable, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_address", address, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    line(1, 8, 0);
    vsync_pulse();
    frame(2, 8, 0, 0);
    check("rst_mid_no_more_wr", 32'(n_wr - base_wr), 32'd2);
    check("rst_mid_no_done", 32'(n_done - base_done), 32'd0);
    check("rst_mid_busy_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
